z3_master_arbiter: RTL and testbench
====================================

Z3_MASTER_ARBITER -- requirements
Module: z3_master_arbiter

Interface
REQ-001 SHALL have parameter TENURE_MAX, default 255, meaning max CLK cycles of bus ownership before forced release request.
REQ-002 SHALL have parameter GRANT_TIMEOUT, default 1023, meaning max CLK cycles waiting for BG_n before abandoning the request.
REQ-003 SHALL have port CLK, input, 1, the single clock for all state.
REQ-004 SHALL have port IORST_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port SBR, input, 1, NCR 53C710 bus request (active high, asynchronous to CLK).
REQ-006 SHALL have port SBG, output, 1, bus grant to the 53C710 (active high).
REQ-007 SHALL have port BR_n, output, 1, Zorro III bus request (active low).
REQ-008 SHALL have port BG_n, input, 1, Zorro III bus grant (active low, asynchronous).
REQ-009 SHALL have port FCS_n, input, 1, Zorro III full-cycle strobe (asynchronous).
REQ-010 SHALL have port DTACK_n, input, 1, Zorro III data acknowledge (asynchronous).
REQ-011 SHALL have port slave_busy, input, 1, high while the card's Z3 slave FSM is not idle.
REQ-012 SHALL have port MASTER, output, 1, card owns the bus (enables address/strobe drivers).
REQ-013 SHALL have port ABOE_n, output, 1, address buffer output enable (active low), equal to !MASTER.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse when a grant wait expires.

Function
REQ-015 SHALL synchronise SBR, BG_n, FCS_n, DTACK_n through two CLK flops each before any use; all latencies below count from the synchronised value.
REQ-016 SHALL implement states IDLE, REQ, WAIT_IDLE, OWN, RELEASE.
REQ-017 IDLE: when SBR=1 and slave_busy=0, SHALL go to REQ next cycle; if slave_busy=1, SHALL stay in IDLE.
REQ-018 REQ: SHALL assert BR_n=0; on BG_n=0 SHALL go to WAIT_IDLE; on SBR=0 SHALL go to IDLE and deassert BR_n.
REQ-019 REQ: SHALL count cycles from entry; at count GRANT_TIMEOUT with no grant SHALL pulse timeout for one cycle, deassert BR_n, go to IDLE.
REQ-020 WAIT_IDLE: SHALL hold BR_n=0; when FCS_n=1, DTACK_n=1 and slave_busy=0 on the same cycle, SHALL go to OWN and deassert BR_n.
REQ-021 WAIT_IDLE: if BG_n returns to 1 before the bus is idle, SHALL return to REQ (timeout counter restarted).
REQ-022 OWN: SHALL assert MASTER=1, ABOE_n=0 and SBG=1; tenure counter SHALL start at 0 on entry and increment each cycle, saturating at TENURE_MAX.
REQ-023 OWN: on SBR=0, SHALL go to RELEASE.
REQ-024 OWN: when tenure counter equals TENURE_MAX, SHALL deassert SBG while holding MASTER; SHALL go to RELEASE once SBR=0.
REQ-025 RELEASE: SHALL deassert SBG; SHALL hold MASTER until FCS_n=1, then deassert MASTER and go to IDLE next cycle.
REQ-026 After RELEASE, SHALL stay in IDLE at least one cycle before re-requesting, even with SBR=1.
REQ-027 SBG SHALL never be 1 while MASTER=0; MASTER SHALL never be 1 while slave_busy was 1 at OWN entry.
REQ-028 Counters SHALL be wide enough for their parameter value; they SHALL not wrap.

Reset
REQ-029 While IORST_n=0: state IDLE, BR_n=1, SBG=0, MASTER=0, ABOE_n=1, timeout=0, counters 0, synchronisers at idle levels (SBR 0, others 1).
REQ-030 Reset asserted in any state, including OWN, SHALL drop MASTER and SBG immediately (asynchronously).
REQ-031 After IORST_n deasserts, SHALL require two synchronised cycles before acting on any input.

Verification
REQ-032 SBR=1, BG_n low 10 cycles after BR_n, bus idle -> MASTER=1 and SBG=1 within 3 cycles of synchronised idle; SBR=0 -> SBG=0 next cycle, MASTER=0 after FCS_n high.
REQ-033 SBR=1, BG_n held high, GRANT_TIMEOUT=16 -> timeout pulses once, 16 cycles after REQ entry; BR_n=1 next cycle; no MASTER.
REQ-034 SBR=1 while slave_busy=1 for 20 cycles -> BR_n stays 1 until slave_busy falls; grant while FCS_n=0 -> OWN only after FCS_n=1.
REQ-035 TENURE_MAX=8, SBR held 1 -> SBG drops after 8 cycles in OWN, MASTER held; SBR then 0 -> RELEASE -> IDLE; no re-request for at least 1 cycle.
REQ-036 IORST_n pulsed low during OWN -> MASTER=0, SBG=0, BR_n=1 same cycle; after release, SBR=1 is acted on only after 2 cycles.
REQ-037 BG_n withdrawn during WAIT_IDLE -> returns to REQ with BR_n=0, MASTER never asserted.

Source files
------------

// File: rtl/z3_master_arbiter.sv
// Zorro III bus-master arbiter for the NCR 53C710 SCSI controller.
// Requests the Z3 bus on behalf of the 53C710, waits for the bus to go
// idle after a grant, hands ownership to the chip and limits its tenure.
module z3_master_arbiter #(
    parameter int unsigned TENURE_MAX    = 255,
    parameter int unsigned GRANT_TIMEOUT = 1023
) (
    input  logic CLK,
    input  logic IORST_n,
    input  logic SBR,
    output logic SBG,
    output logic BR_n,
    input  logic BG_n,
    input  logic FCS_n,
    input  logic DTACK_n,
    input  logic slave_busy,
    output logic MASTER,
    output logic ABOE_n,
    output logic timeout
);

    localparam int unsigned TW = (TENURE_MAX    == 0) ? 1 : $clog2(TENURE_MAX + 1);
    localparam int unsigned GW = (GRANT_TIMEOUT == 0) ? 1 : $clog2(GRANT_TIMEOUT + 1);
    localparam logic [TW-1:0] TEN_LIMIT   = TW'(TENURE_MAX);
    localparam logic [GW-1:0] GRANT_LIMIT = GW'(GRANT_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_IDLE,
        ST_OWN,
        ST_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] ten_q, ten_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          hold_q, hold_d;

    logic [1:0] sbr_sync, bg_sync, fcs_sync, dtack_sync;
    logic       sbr_s, bg_n_s, fcs_n_s, dtack_n_s;

    // Two-flop synchronisers for the asynchronous inputs, reset to idle levels
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            sbr_sync   <= '0;
            bg_sync    <= '1;
            fcs_sync   <= '1;
            dtack_sync <= '1;
        end else begin
            sbr_sync   <= {sbr_sync[0],   SBR};
            bg_sync    <= {bg_sync[0],    BG_n};
            fcs_sync   <= {fcs_sync[0],   FCS_n};
            dtack_sync <= {dtack_sync[0], DTACK_n};
        end
    end

    assign sbr_s     = sbr_sync[1];
    assign bg_n_s    = bg_sync[1];
    assign fcs_n_s   = fcs_sync[1];
    assign dtack_n_s = dtack_sync[1];

    // State, counters and post-release guard flag
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q <= ST_IDLE;
            ten_q   <= '0;
            grant_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ten_q   <= ten_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state, counter update and output decode
    always_comb begin
        state_d = state_q;
        ten_d   = '0;
        grant_d = '0;
        hold_d  = 1'b0;
        BR_n    = 1'b1;
        SBG     = 1'b0;
        MASTER  = 1'b0;
        timeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // hold_q blocks the first IDLE cycle after a release
                if (sbr_s && !slave_busy && !hold_q)
                    state_d = ST_REQ;
            end

            ST_REQ: begin
                BR_n = 1'b0;
                if (!bg_n_s) begin
                    state_d = ST_WAIT_IDLE;
                end else if (grant_q == GRANT_LIMIT) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else if (!sbr_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                BR_n = 1'b0;
                if (bg_n_s)
                    state_d = ST_REQ;
                else if (fcs_n_s && dtack_n_s && !slave_busy)
                    state_d = ST_OWN;
            end

            ST_OWN: begin
                MASTER = 1'b1;
                SBG    = (ten_q != TEN_LIMIT);
                if (!sbr_s)
                    state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                MASTER = 1'b1;
                if (fcs_n_s)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Counters clear whenever their state is entered or left
        if (state_q == ST_REQ && state_d == ST_REQ)
            grant_d = (grant_q == GRANT_LIMIT) ? grant_q : grant_q + 1'b1;
        if (state_q == ST_OWN && state_d == ST_OWN)
            ten_d = (ten_q == TEN_LIMIT) ? ten_q : ten_q + 1'b1;
        hold_d = (state_q == ST_RELEASE) && (state_d == ST_IDLE);
    end

    assign ABOE_n = !MASTER;

endmodule

// File: tb/tb_z3_master_arbiter.sv
// Directed bench for z3_master_arbiter: a cycle-by-cycle vector table for
// the basic grant/own/release flow, then hand-written multi-cycle sequences.
module tb_z3_master_arbiter;

    logic CLK = 1'b0;
    logic IORST_n, SBR, BG_n, FCS_n, DTACK_n, slave_busy;
    logic SBG, BR_n, MASTER, ABOE_n, timeout;

    int n_vec = 0;
    int n_err = 0;

    z3_master_arbiter #(.TENURE_MAX(8), .GRANT_TIMEOUT(16)) dut (
        .CLK(CLK), .IORST_n(IORST_n), .SBR(SBR), .SBG(SBG), .BR_n(BR_n),
        .BG_n(BG_n), .FCS_n(FCS_n), .DTACK_n(DTACK_n), .slave_busy(slave_busy),
        .MASTER(MASTER), .ABOE_n(ABOE_n), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    // inputs: sbr bg_n fcs_n dtack_n busy ; expected: br_n sbg master timeout
    typedef struct packed {
        logic sbr, bg_n, fcs_n, dtack_n, busy;
        logic br_n, sbg, master, to;
    } vec_t;

    vec_t vecs [19];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic bg, input logic f, input logic d, input logic b);
        SBR = s; BG_n = bg; FCS_n = f; DTACK_n = d; slave_busy = b;
    endtask

    task automatic settle();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) tick();
    endtask

    // Structural invariants sampled on the falling edge
    always @(negedge CLK) begin
        if (IORST_n === 1'b1) begin
            if (SBG && !MASTER) begin
                n_err++;
                $display("FAIL sbg_without_master: SBG=%b MASTER=%b", SBG, MASTER);
            end
            if (ABOE_n !== !MASTER) begin
                n_err++;
                $display("FAIL aboe_n: ABOE_n=%b MASTER=%b", ABOE_n, MASTER);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic found, bad;

        //               s b f d y   B G M T
        vecs[0]  = 9'b1_1_1_1_0__1_0_0_0; // IDLE, SBR in synchroniser
        vecs[1]  = 9'b1_1_1_1_0__1_0_0_0;
        vecs[2]  = 9'b1_0_0_1_0__0_0_0_0; // REQ
        vecs[3]  = 9'b1_0_0_1_0__0_0_0_0;
        vecs[4]  = 9'b1_0_0_1_0__0_0_0_0; // WAIT_IDLE
        vecs[5]  = 9'b1_0_1_0_0__0_0_0_0; // FCS_n low still seen
        vecs[6]  = 9'b1_0_1_1_0__0_0_0_0;
        vecs[7]  = 9'b1_0_1_1_0__0_0_0_0; // DTACK_n low seen
        vecs[8]  = 9'b1_0_1_1_0__1_1_1_0; // OWN
        vecs[9]  = 9'b0_0_1_1_0__1_1_1_0;
        vecs[10] = 9'b0_1_0_1_0__1_1_1_0;
        vecs[11] = 9'b0_1_0_1_0__1_0_1_0; // RELEASE
        vecs[12] = 9'b1_1_0_1_0__1_0_1_0;
        vecs[13] = 9'b1_1_1_1_0__1_0_1_0;
        vecs[14] = 9'b1_1_1_1_0__1_0_1_0;
        vecs[15] = 9'b1_1_1_1_0__1_0_0_0; // IDLE after release
        vecs[16] = 9'b0_1_1_1_0__1_0_0_0; // guard cycle despite SBR
        vecs[17] = 9'b0_1_1_1_0__0_0_0_0; // REQ
        vecs[18] = 9'b0_1_1_1_0__1_0_0_0; // SBR dropped -> IDLE

        IORST_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        check("reset_outputs", {27'd0, BR_n, SBG, MASTER, ABOE_n, timeout}, 32'b10010);
        IORST_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].sbr, vecs[i].bg_n, vecs[i].fcs_n, vecs[i].dtack_n, vecs[i].busy);
            tick();
            check($sformatf("vec%0d", i), {28'd0, BR_n, SBG, MASTER, timeout},
                  {28'd0, vecs[i].br_n, vecs[i].sbg, vecs[i].master, vecs[i].to});
        end

        // Grant timeout with BG_n held high
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n = 0; found = 1'b0; bad = 1'b0;
        while (!found && n < 10) begin
            tick(); n++;
            if (BR_n == 1'b0) found = 1'b1;
        end
        check("req_entry_latency", n, 3);
        n = 0; found = 1'b0;
        while (!found && n < 40) begin
            tick(); n++;
            if (MASTER) bad = 1'b1;
            if (timeout) found = 1'b1;
        end
        check("timeout_cycles", n, 16);
        check("timeout_br_n_during", BR_n, 0);
        tick();
        check("timeout_one_pulse", timeout, 0);
        check("timeout_br_n_after", BR_n, 1);
        check("timeout_no_master", bad, 0);
        settle();

        // Request blocked by slave_busy, then grant while FCS_n low
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (BR_n == 1'b0 || MASTER) bad = 1'b1;
        end
        check("busy_blocks_request", bad, 0);
        slave_busy = 1'b0;
        tick();
        check("busy_release_req", BR_n, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (MASTER) bad = 1'b1;
        end
        check("fcs_low_blocks_own", bad, 0);
        FCS_n = 1'b1;
        tick(); tick();
        check("fcs_sync_latency", MASTER, 0);
        tick();
        check("own_entry", {29'd0, BR_n, SBG, MASTER}, 32'b111);
        tick(); tick();

        // Asynchronous reset during OWN, then two-cycle input latency
        IORST_n = 1'b0;
        #2;
        check("reset_in_own", {27'd0, MASTER, SBG, BR_n, ABOE_n, timeout}, 32'b00110);
        tick(); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        IORST_n = 1'b1;
        tick();
        check("post_reset_cycle1", BR_n, 1);
        tick();
        check("post_reset_cycle2", BR_n, 1);
        tick();
        check("post_reset_req", BR_n, 0);

        // Grant withdrawn during WAIT_IDLE: back to REQ with a fresh timeout
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (BR_n != 1'b0 || MASTER) bad = 1'b1;
        end
        check("wait_idle_holds_br", bad, 0);
        BG_n = 1'b1;
        n = 0; found = 1'b0; bad = 1'b0;
        while (!found && n < 40) begin
            tick(); n++;
            if (MASTER || BR_n) bad = 1'b1;
            if (timeout) found = 1'b1;
        end
        check("withdraw_timeout_cycles", n, 19);
        check("withdraw_no_master", bad, 0);
        settle();

        // Tenure limit with SBR held high
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            tick(); n++;
            if (MASTER) found = 1'b1;
        end
        check("tenure_own_reached", found, 1);
        bad = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (!SBG) bad = 1'b1;
        end
        check("tenure_sbg_held", bad, 0);
        tick();
        check("tenure_sbg_drop", {30'd0, SBG, MASTER}, 32'b01);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (SBG || !MASTER) bad = 1'b1;
        end
        check("tenure_saturated", bad, 0);
        SBR = 1'b0;
        tick(); tick(); tick();
        check("tenure_release_master", {30'd0, SBG, MASTER}, 32'b01);
        tick();
        check("tenure_idle", {30'd0, MASTER, BR_n}, 32'b01);
        tick();
        check("tenure_no_rereq", BR_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
